// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the UART-driven register file controller:
// frame opcodes and the controller state encoding.
package reg_file_ctrl_pkg;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_DO,
        RD_ADDR,
        RD_REQ,
        RD_WAIT,
        TX_HOLD
    } state_t;

endpackage

// File: rtl/reg_file_ctrl_if.sv
// Bundle of the UART byte streams and the register file access port
// seen by the controller (master) and its environment (slave).
interface reg_file_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LINES = 16
);
    localparam int ADDR_W = $clog2(LINES);

    logic [WIDTH-1:0]  rx_data;
    logic              rx_valid;
    logic [WIDTH-1:0]  tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  rd_data;
    logic              err;

    modport master (
        input  rx_data, rx_valid, tx_ready, rd_data,
        output tx_data, tx_valid, wr_en, rd_en, addr, wr_data, err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, rd_data,
        input  tx_data, tx_valid, wr_en, rd_en, addr, wr_data, err
    );

endinterface

// File: rtl/reg_file_ctrl.sv
// Decodes UART write (AA addr data) and read (BB addr) frames into single-cycle
// register file strobes and returns read data to the UART transmitter.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LINES = 16
) (
    input logic             clk,
    input logic             rst,
    reg_file_ctrl_if.master bus
);
    localparam int ADDR_W = $clog2(LINES);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [WIDTH-1:0]  tx_data_q;
    logic              err_q;

    logic addr_ld, data_ld, tx_ld, err_next;
    logic addr_ok;

    // Out-of-range addresses are rejected before they reach the latched address.
    assign addr_ok = 32'(bus.rx_data) < LINES;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        addr_ld    = 1'b0;
        data_ld    = 1'b0;
        tx_ld      = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == WIDTH'(WR_CMD))      state_next = WR_ADDR;
                    else if (bus.rx_data == WIDTH'(RD_CMD)) state_next = RD_ADDR;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (bus.rx_valid) begin
                    if (addr_ok) begin
                        addr_ld    = 1'b1;
                        state_next = (state == WR_ADDR) ? WR_DATA : RD_REQ;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (bus.rx_valid) begin
                    data_ld    = 1'b1;
                    state_next = WR_DO;
                end
            end
            // Bytes arriving while an access is in flight are dropped and flagged.
            WR_DO: begin
                err_next   = bus.rx_valid;
                state_next = IDLE;
            end
            RD_REQ: begin
                err_next   = bus.rx_valid;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                err_next   = bus.rx_valid;
                tx_ld      = 1'b1;
                state_next = TX_HOLD;
            end
            TX_HOLD: begin
                err_next = bus.rx_valid;
                if (bus.tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (addr_ld) addr_q    <= bus.rx_data[ADDR_W-1:0];
            if (data_ld) wr_data_q <= bus.rx_data;
            if (tx_ld)   tx_data_q <= bus.rd_data;
            err_q <= err_next;
        end
    end

    assign bus.wr_en    = (state == WR_DO);
    assign bus.rd_en    = (state == RD_REQ);
    assign bus.tx_valid = (state == TX_HOLD);
    assign bus.addr     = addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.err      = err_q;

endmodule
